// File: rtl/clkdiv_cfg_arbiter_if.sv
// Bus bundle between clkdiv_cfg_arbiter and its requesters / divider.
// slave  : the arbiter side (samples requests, drives divider write port).
// master : the environment side (requesters plus divider clock output).
interface clkdiv_cfg_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_div;
    logic [NUM_REQ-1:0]   gnt;
    logic                 busy;
    logic [7:0]           cur_div;
    logic [6:0]           div_address;
    logic [7:0]           div_writedata;
    logic                 div_write;
    logic                 div_clk_out;
    logic                 timeout_flag;

    modport slave (
        input  req, req_div, div_clk_out,
        output gnt, busy, cur_div, div_address, div_writedata, div_write, timeout_flag
    );

    modport master (
        output req, req_div, div_clk_out,
        input  gnt, busy, cur_div, div_address, div_writedata, div_write, timeout_flag
    );
endinterface

// File: rtl/clkdiv_cfg_arbiter.sv
// clkdiv_cfg_arbiter: round-robin sharing of one programmable clock divider.
// Ratio writes are issued only on a falling edge of div_clk_out, followed by a
// settle window before the requester is acknowledged. A boot write of DIV_RESET
// follows every reset.
// Optional feature: define CLKDIV_TIMEOUT_EN to bound the wait for a falling
// edge to TIMEOUT_CYC cycles (forced write + sticky timeout_flag).
module clkdiv_cfg_arbiter #(
    parameter int         NUM_REQ     = 4,
    parameter logic [7:0] DIV_RESET   = 8'd50,
    parameter logic [6:0] DIV_ADDR    = 7'd0,
    parameter int         SETTLE_CYC  = 16,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clkdiv_cfg_arbiter_if.slave  bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_BOOT, S_IDLE, S_ARB, S_WAIT_EDGE, S_WRITE, S_SETTLE, S_ACK
    } state_t;

    state_t        state_q, state_d;
    logic          clk_q;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [7:0]    pending_q, pending_d;
    logic          boot_q, boot_d;
    logic [7:0]    cur_div_q, cur_div_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [SW-1:0] settle_q, settle_d;

    logic          fall;
    logic          timeout_hit;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [7:0]    win_div;
    logic [7:0]    req_div_arr [NUM_REQ];

    assign fall = clk_q & ~bus.div_clk_out;

    // Per-requester views: ratio slices and one-hot acknowledge bits.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_div_arr[gi] = bus.req_div[8*gi +: 8];
        assign bus.gnt[gi]     = (state_q == S_ACK) && (owner_q == IW'(gi));
    end

    // Round-robin search: first set request at or after rr_q, wrapping.
    always_comb begin
        logic [IW:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!win_found && bus.req[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
        // A ratio of 0 is meaningless for the divider; treat it as 1.
        win_div = (req_div_arr[win_idx] == 8'd0) ? 8'd1 : req_div_arr[win_idx];
    end

    // Next-state and datapath updates for the transaction FSM.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        pending_d = pending_q;
        boot_d    = boot_q;
        cur_div_d = cur_div_q;
        wdata_d   = wdata_q;
        settle_d  = settle_q;
        case (state_q)
            S_BOOT: begin
                pending_d = DIV_RESET;
                boot_d    = 1'b1;
                state_d   = S_WAIT_EDGE;
            end
            S_IDLE: begin
                if (|bus.req) state_d = S_ARB;
            end
            S_ARB: begin
                if (win_found) begin
                    owner_d   = win_idx;
                    rr_d      = (win_idx == LAST_IDX) ? '0 : win_idx + IW'(1);
                    pending_d = win_div;
                    boot_d    = 1'b0;
                    state_d   = (win_div == cur_div_q) ? S_ACK : S_WAIT_EDGE;
                end else begin
                    // Request withdrawn between IDLE and ARB: nothing to serve.
                    state_d = S_IDLE;
                end
            end
            S_WAIT_EDGE: begin
                if (fall || timeout_hit) begin
                    wdata_d = pending_q;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                cur_div_d = pending_q;
                settle_d  = '0;
                state_d   = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = boot_q ? S_IDLE : S_ACK;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: state_d = S_BOOT;
        endcase
    end

    // State and datapath registers; reset restarts with a boot write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BOOT;
            clk_q     <= 1'b0;
            rr_q      <= '0;
            owner_q   <= '0;
            pending_q <= DIV_RESET;
            boot_q    <= 1'b1;
            cur_div_q <= DIV_RESET;
            wdata_q   <= DIV_RESET;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            clk_q     <= bus.div_clk_out;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            pending_q <= pending_d;
            boot_q    <= boot_d;
            cur_div_q <= cur_div_d;
            wdata_q   <= wdata_d;
            settle_q  <= settle_d;
        end
    end

`ifdef CLKDIV_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] to_cnt_q;
    logic          to_flag_q;

    assign timeout_hit      = (state_q == S_WAIT_EDGE) && !fall && (to_cnt_q == TO_LAST);
    assign bus.timeout_flag = to_flag_q;

    // Counts cycles spent waiting for a falling edge; flag is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            if (state_q == S_WAIT_EDGE && !fall && !timeout_hit) begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end else begin
                to_cnt_q <= '0;
            end
            if (timeout_hit) to_flag_q <= 1'b1;
        end
    end
`else
    assign timeout_hit      = 1'b0;
    assign bus.timeout_flag = 1'b0;
`endif

    assign bus.busy          = (state_q != S_IDLE);
    assign bus.cur_div       = cur_div_q;
    assign bus.div_address   = DIV_ADDR;
    assign bus.div_writedata = wdata_q;
    assign bus.div_write     = (state_q == S_WRITE);
endmodule

// File: tb/tb_clkdiv_cfg_arbiter.sv
// Directed testbench for clkdiv_cfg_arbiter (default parameters).
module tb_clkdiv_cfg_arbiter;
    localparam int SETTLE_CYC  = 16;
    localparam int TIMEOUT_CYC = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic div_auto = 1'b0;
    logic div_man = 1'b1;
    logic div_tog = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [7:0] wr_log [64];
    int         wr_n = 0;
    int         gnt_log [64];
    int         gnt_n = 0;

    clkdiv_cfg_arbiter_if #(.NUM_REQ(4)) bus_if ();

    clkdiv_cfg_arbiter #(
        .NUM_REQ(4), .DIV_RESET(8'd50), .DIV_ADDR(7'd0),
        .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    // Free-running divider model: falls every second clk cycle when enabled.
    always @(posedge clk) div_tog <= ~div_tog;
    assign bus_if.div_clk_out = div_auto ? div_tog : div_man;

    function automatic int first_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Transaction monitor: one line per divider write and per grant.
    always @(negedge clk) begin
        if (bus_if.div_write) begin
            if (wr_n < 64) wr_log[wr_n] <= bus_if.div_writedata;
            wr_n <= wr_n + 1;
            $display("[%0t] write addr=%0d data=%0d", $time, bus_if.div_address, bus_if.div_writedata);
        end
        if (bus_if.gnt != 4'b0) begin
            if (gnt_n < 64) gnt_log[gnt_n] <= first_idx(bus_if.gnt);
            gnt_n <= gnt_n + 1;
            $display("[%0t] gnt=%b cur_div=%0d", $time, bus_if.gnt, bus_if.cur_div);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold the masked requests until each is granted, bounded by budget cycles.
    task automatic serve(input string tag, input logic [3:0] mask, input logic [31:0] divs,
                         input int budget);
        int n;
        bus_if.req_div = divs;
        bus_if.req     = mask;
        n = 0;
        while (bus_if.req != 4'b0 && n < budget) begin
            step(1);
            n++;
            if (bus_if.gnt != 4'b0) bus_if.req = bus_if.req & ~bus_if.gnt;
        end
        chk({tag, "_done"}, 32'(bus_if.req), 32'd0);
        step(1);
    endtask

    initial begin
        int w0;
        int g0;
        int n;
        bus_if.req     = 4'b0;
        bus_if.req_div = 32'd0;

        // Reset values
        step(3);
        chk("rst_gnt",   32'(bus_if.gnt), 32'd0);
        chk("rst_busy",  32'(bus_if.busy), 32'd1);
        chk("rst_cur",   32'(bus_if.cur_div), 32'd50);
        chk("rst_addr",  32'(bus_if.div_address), 32'd0);
        chk("rst_wdata", 32'(bus_if.div_writedata), 32'd50);
        chk("rst_write", 32'(bus_if.div_write), 32'd0);
        chk("rst_tflag", 32'(bus_if.timeout_flag), 32'd0);

        // Boot write: only on a fall, then busy for SETTLE_CYC+1 cycles
        rst_n = 1'b1;
        step(3);
        chk("boot_nowrite_no_fall", 32'(bus_if.div_write), 32'd0);
        div_man = 1'b0;
        step(1);
        chk("boot_write",  32'(bus_if.div_write), 32'd1);
        chk("boot_wdata",  32'(bus_if.div_writedata), 32'd50);
        chk("boot_addr",   32'(bus_if.div_address), 32'd0);
        step(SETTLE_CYC);
        chk("boot_busy_settle", 32'(bus_if.busy), 32'd1);
        step(1);
        chk("boot_busy_drop", 32'(bus_if.busy), 32'd0);
        chk("boot_no_gnt", 32'(gnt_n), 32'd0);

        // Contention from pointer 0: served 0,1,2,3
        div_auto = 1'b1;
        w0 = wr_n;
        g0 = gnt_n;
        serve("contend", 4'b1111, {8'd6, 8'd5, 8'd4, 8'd3}, 500);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("contend_gnt%0d", k), 32'(gnt_log[g0+k]), 32'(k));
            chk($sformatf("contend_wr%0d", k), 32'(wr_log[w0+k]), 32'(k + 3));
        end
        chk("contend_cur", 32'(bus_if.cur_div), 32'd6);

        // Re-request 0 and 3 with pointer back at 0: 0 first
        w0 = wr_n;
        g0 = gnt_n;
        serve("rereq", 4'b1001, {8'd8, 8'd0, 8'd0, 8'd7}, 300);
        chk("rereq_first",  32'(gnt_log[g0]), 32'd0);
        chk("rereq_second", 32'(gnt_log[g0+1]), 32'd3);
        chk("rereq_wr0",    32'(wr_log[w0]), 32'd7);
        chk("rereq_wr1",    32'(wr_log[w0+1]), 32'd8);

        // Single change with controlled edge timing
        div_man  = 1'b1;
        div_auto = 1'b0;
        step(2);
        w0 = wr_n;
        bus_if.req_div = {8'd0, 8'd0, 8'd10, 8'd0};
        bus_if.req     = 4'b0010;
        step(1);
        chk("single_arb_busy", 32'(bus_if.busy), 32'd1);
        step(3);
        chk("single_wait_nowrite", 32'(bus_if.div_write), 32'd0);
        div_man = 1'b0;
        step(1);
        chk("single_write", 32'(bus_if.div_write), 32'd1);
        chk("single_wdata", 32'(bus_if.div_writedata), 32'd10);
        n = 0;
        while (bus_if.gnt == 4'b0 && n < 100) begin
            step(1);
            n++;
        end
        chk("single_gnt_latency", 32'(n), 32'(SETTLE_CYC + 1));
        chk("single_gnt", 32'(bus_if.gnt), 32'b0010);
        chk("single_cur", 32'(bus_if.cur_div), 32'd10);
        bus_if.req = 4'b0;
        step(1);
        chk("single_gnt_pulse", 32'(bus_if.gnt), 32'd0);
        chk("single_idle", 32'(bus_if.busy), 32'd0);
        w0 = wr_n;

        // No-op request: ratio equals cur_div
        bus_if.req_div = {8'd0, 8'd10, 8'd0, 8'd0};
        bus_if.req     = 4'b0100;
        step(1);
        chk("noop_arb_gnt", 32'(bus_if.gnt), 32'd0);
        step(1);
        chk("noop_gnt", 32'(bus_if.gnt), 32'b0100);
        bus_if.req = 4'b0;
        step(1);
        chk("noop_no_write", 32'(wr_n - w0), 32'd0);
        chk("noop_gnt_pulse", 32'(bus_if.gnt), 32'd0);

        // Zero ratio coerced to 1
        div_auto = 1'b1;
        w0 = wr_n;
        serve("zero", 4'b0001, {8'd0, 8'd0, 8'd0, 8'd0}, 200);
        chk("zero_wdata", 32'(wr_log[w0]), 32'd1);
        chk("zero_cur", 32'(bus_if.cur_div), 32'd1);

        // Reset during SETTLE: no grant, boot write repeats
        bus_if.req_div = {8'd20, 8'd0, 8'd0, 8'd0};
        bus_if.req     = 4'b1000;
        n = 0;
        while (bus_if.div_write == 1'b0 && n < 100) begin
            step(1);
            n++;
        end
        chk("abort_write_seen", 32'(bus_if.div_write), 32'd1);
        step(3);
        g0 = gnt_n;
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  32'(bus_if.busy), 32'd1);
        chk("abort_cur",   32'(bus_if.cur_div), 32'd50);
        chk("abort_wdata", 32'(bus_if.div_writedata), 32'd50);
        chk("abort_gnt",   32'(bus_if.gnt), 32'd0);
        bus_if.req = 4'b0;
        step(2);
        w0 = wr_n;
        rst_n = 1'b1;
        n = 0;
        while (!(bus_if.busy == 1'b0 && n > 2) && n < 200) begin
            step(1);
            n++;
        end
        chk("reboot_idle", 32'(bus_if.busy), 32'd0);
        chk("reboot_writes", 32'(wr_n - w0), 32'd1);
        chk("reboot_wdata", 32'(wr_log[w0]), 32'd50);
        chk("abort_no_gnt", 32'(gnt_n - g0), 32'd0);

        // Divider stalled low: timeout behaviour
        div_man  = 1'b0;
        div_auto = 1'b0;
        step(2);
        w0 = wr_n;
        bus_if.req_div = {8'd0, 8'd0, 8'd30, 8'd0};
        bus_if.req     = 4'b0010;
        step(2);
`ifdef CLKDIV_TIMEOUT_EN
        step(TIMEOUT_CYC - 1);
        chk("to_not_yet", 32'(bus_if.div_write), 32'd0);
        step(1);
        chk("to_write", 32'(bus_if.div_write), 32'd1);
        chk("to_wdata", 32'(bus_if.div_writedata), 32'd30);
        chk("to_flag",  32'(bus_if.timeout_flag), 32'd1);
        n = 0;
        while (bus_if.gnt == 4'b0 && n < 100) begin
            step(1);
            n++;
        end
        chk("to_gnt", 32'(bus_if.gnt), 32'b0010);
        bus_if.req = 4'b0;
        step(1);
        chk("to_flag_sticky", 32'(bus_if.timeout_flag), 32'd1);
`else
        step(1200);
        chk("stall_busy",  32'(bus_if.busy), 32'd1);
        chk("stall_nowr",  32'(wr_n - w0), 32'd0);
        chk("stall_tflag", 32'(bus_if.timeout_flag), 32'd0);
        chk("stall_cur",   32'(bus_if.cur_div), 32'd50);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
